// File: rtl/disp_ctrl_pkg.sv
// rtl/disp_ctrl_pkg.sv - shared widths and skid-buffer state encoding for the dispatch controller
//
// Contents:
//   DEF_PC_W / DEF_INST_W / DEF_REG_AW / DEF_CNT_W : default widths
//   buf_state_e : skid buffer occupancy (EMPTY, ONE, TWO)
package disp_ctrl_pkg;

    localparam int DEF_PC_W   = 32;
    localparam int DEF_INST_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/disp_skid_buf.sv
// rtl/disp_skid_buf.sv - generic 2-entry valid/ready skid buffer with flush
//
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   flush                     : discard all entries, next state EMPTY
//   in_valid/in_ready/in_data : upstream handshake (in_ready registered)
//   out_valid/out_ready/out_data : head entry (entry 0) handshake
module disp_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    import disp_ctrl_pkg::*;

    buf_state_e   state_q, state_d;
    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic         ready_q;
    logic         push, pop;

    assign push      = in_valid & ready_q;
    assign out_valid = (state_q != BUF_EMPTY);
    assign pop       = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign out_data  = e0_q;

    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    state_d = BUF_ONE;
                    e0_d    = in_data;
                end
            end
            BUF_ONE: begin
                if (push && pop) begin
                    // head leaves and the new entry takes its place
                    e0_d = in_data;
                end else if (push) begin
                    state_d = BUF_TWO;
                    e1_d    = in_data;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    state_d = BUF_ONE;
                    e0_d    = e1_q;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        // flush wins over any accept in the same cycle; stale payload is harmless
        if (flush) begin
            state_d = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BUF_EMPTY;
            ready_q <= 1'b1;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != BUF_TWO);
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

endmodule

// File: rtl/disp_ctrl.sv
// rtl/disp_ctrl.sv - in-order dispatch from decoder to execute with scoreboard gating and stall counters
//
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   dec_*                          : decoder handshake and instruction fields
//   sb_rs1/sb_rs2/sb_rd/sb_regwr   : scoreboard query and allocate strobe
//   sb_raw/sb_full                 : scoreboard hazard / full indications
//   exu_*                          : execute unit handshake and head payload
//   flush                          : redirect, drop everything buffered
//   cnt_raw/full/exu_stall         : saturating stall counters
module disp_ctrl import disp_ctrl_pkg::*; #(
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [PC_W-1:0]   dec_pc,
    input  logic [INST_W-1:0] dec_inst,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_rs1_en,
    input  logic              dec_rs2_en,
    input  logic              dec_rd_wen,
    output logic [REG_AW-1:0] sb_rs1,
    output logic [REG_AW-1:0] sb_rs2,
    output logic [REG_AW-1:0] sb_rd,
    output logic              sb_regwr,
    input  logic              sb_raw,
    input  logic              sb_full,
    output logic              exu_valid,
    input  logic              exu_ready,
    output logic [PC_W-1:0]   exu_pc,
    output logic [INST_W-1:0] exu_inst,
    output logic [REG_AW-1:0] exu_rd,
    output logic              exu_rd_wen,
    input  logic              flush,
    output logic [CNT_W-1:0]  cnt_raw_stall,
    output logic [CNT_W-1:0]  cnt_full_stall,
    output logic [CNT_W-1:0]  cnt_exu_stall
);

    localparam int PW = PC_W + INST_W + 3 * REG_AW + 3;

    logic [PW-1:0]     in_data, head_data;
    logic              head_valid, head_ready, issue;
    logic [PC_W-1:0]   h_pc;
    logic [INST_W-1:0] h_inst;
    logic [REG_AW-1:0] h_rs1, h_rs2, h_rd;
    logic              h_rs1_en, h_rs2_en, h_rd_wen;

    assign in_data = {dec_pc, dec_inst, dec_rs1, dec_rs2, dec_rd,
                      dec_rs1_en, dec_rs2_en, dec_rd_wen};
    assign {h_pc, h_inst, h_rs1, h_rs2, h_rd, h_rs1_en, h_rs2_en, h_rd_wen} = head_data;

    // the buffer only sees a pop when every issue condition holds
    assign head_ready = exu_ready & ~sb_raw & ~sb_full & ~flush;

    disp_skid_buf #(.W(PW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (dec_valid),
        .in_ready  (dec_ready),
        .in_data   (in_data),
        .out_valid (head_valid),
        .out_ready (head_ready),
        .out_data  (head_data)
    );

    assign exu_valid  = head_valid & ~sb_raw & ~sb_full & ~flush;
    assign issue      = exu_valid & exu_ready;
    assign exu_pc     = h_pc;
    assign exu_inst   = h_inst;
    assign exu_rd     = h_rd;
    assign exu_rd_wen = h_rd_wen;

    // unused sources and an empty buffer query x0, which never hits
    assign sb_rs1   = (head_valid && h_rs1_en) ? h_rs1 : '0;
    assign sb_rs2   = (head_valid && h_rs2_en) ? h_rs2 : '0;
    assign sb_rd    = h_rd;
    assign sb_regwr = issue & h_rd_wen & (h_rd != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_raw_stall  <= '0;
            cnt_full_stall <= '0;
            cnt_exu_stall  <= '0;
        end else if (head_valid && !flush) begin
            if (sb_raw) begin
                if (cnt_raw_stall != '1) cnt_raw_stall <= cnt_raw_stall + 1'b1;
            end else if (sb_full) begin
                if (cnt_full_stall != '1) cnt_full_stall <= cnt_full_stall + 1'b1;
            end else if (!exu_ready) begin
                if (cnt_exu_stall != '1) cnt_exu_stall <= cnt_exu_stall + 1'b1;
            end
        end
    end

endmodule
